// File: rtl/button_pio_irq.sv
// Avalon-MM input PIO for buttons/switches: synchroniser, optional debounce filter,
// per-bit edge capture, interrupt mask and one level IRQ. Debounce enabled by BUTTON_PIO_DEBOUNCE_EN.
module button_pio_irq #(
   parameter int WIDTH           = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = 1,
   parameter int IDLE_LEVEL      = 1,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{1'(IDLE_LEVEL)}};

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0] r_filt;
   logic [WIDTH-1:0] r_ecap;
   logic [WIDTH-1:0] r_mask;
   logic [31:0]      r_readdata;

   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] w_filt_next;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_ev;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;
   logic [31:0]      w_rdata;
   logic             w_unused_wdata;

   // Synchroniser resets to the idle level so reset release never looks like a press.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= {SYNC_STAGES{IDLE_VEC}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
      end
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef BUTTON_PIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt [WIDTH];

   always_comb begin
      w_filt_next = r_filt;
      for (int i = 0; i < WIDTH; i++) begin
         if (w_sync[i] != r_filt[i] && r_cnt[i] == CNT_MAX) begin
            w_filt_next[i] = w_sync[i];
         end
      end
   end

   // Any return to the filtered level restarts the stability count.
   // NOTE: the counter array is control state, so every entry is reset, unlike a data RAM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (w_sync[i] == r_filt[i] || r_cnt[i] == CNT_MAX) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign w_filt_next = w_sync;
`endif

   assign w_rise = w_filt_next & ~r_filt;
   assign w_fall = ~w_filt_next & r_filt;
   assign w_ev   = (EDGE_TYPE == 0) ? w_rise :
                   (EDGE_TYPE == 1) ? w_fall : (w_rise | w_fall);

   assign w_wr  = chipselect & ~write_n;
   assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // Upper write-data bits beyond WIDTH are architecturally ignored.
   assign w_unused_wdata = ^writedata;

   // A new event in the same cycle as a clear keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_filt <= IDLE_VEC;
         r_ecap <= '0;
         r_mask <= '0;
      end else begin
         r_filt <= w_filt_next;
         r_ecap <= w_ev | (r_ecap & ~w_clr);
         if (w_wr && address == 2'd2) begin
            r_mask <= writedata[WIDTH-1:0];
         end
      end
   end

   // NOTE: defaulting w_rdata first keeps the read mux purely combinational (no latch).
   always_comb begin
      w_rdata = '0;
      case (address)
         2'd0:    w_rdata[WIDTH-1:0] = r_filt;
         2'd2:    w_rdata[WIDTH-1:0] = r_mask;
         2'd3:    w_rdata[WIDTH-1:0] = r_ecap;
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rdata;
      end
   end

   assign readdata = r_readdata;
   assign irq      = |(r_ecap & r_mask);

endmodule

// File: tb/tb_button_pio_irq.sv
// Directed self-checking bench for button_pio_irq: a 2-bit falling-edge instance and an
// 8-bit any-edge instance; with BUTTON_PIO_DEBOUNCE_EN the debounce sequence runs instead.
module tb_button_pio_irq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        cs_a = 1'b0;
   logic        cs_b = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] rd_a;
   logic [31:0] rd_b;
   logic [1:0]  in_a = 2'b11;
   logic [7:0]  in_b = 8'hFF;
   logic        irq_a;
   logic        irq_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   button_pio_irq #(
      .WIDTH(2), .SYNC_STAGES(2), .EDGE_TYPE(1), .IDLE_LEVEL(1), .DEBOUNCE_CYCLES(4)
   ) u_dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
      .write_n(write_n), .writedata(writedata), .readdata(rd_a),
      .in_port(in_a), .irq(irq_a)
   );

   button_pio_irq #(
      .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IDLE_LEVEL(1), .DEBOUNCE_CYCLES(4)
   ) u_dut_b (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
      .write_n(write_n), .writedata(writedata), .readdata(rd_b),
      .in_port(in_b), .irq(irq_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic sel_b, input logic [1:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write_n   = 1'b0;
      if (sel_b) cs_b = 1'b1;
      else       cs_a = 1'b1;
      @(negedge clk);
      cs_a    = 1'b0;
      cs_b    = 1'b0;
      write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a);
      address = a;
      @(negedge clk);
   endtask

   initial begin
      // Reset with inputs at the idle level
      cyc(3);
      check("rst_readdata_a", rd_a, 32'h0);
      check("rst_readdata_b", rd_b, 32'h0);
      check("rst_irq_a", 32'(irq_a), 32'h0);
      reset_n = 1'b1;
      rd(2'd0);
      check("post_rst_data", rd_a, 32'h3);
      rd(2'd3);
      check("post_rst_ecap", rd_a, 32'h0);
      check("post_rst_irq", 32'(irq_a), 32'h0);

`ifndef BUTTON_PIO_DEBOUNCE_EN
      // Bits above WIDTH are dropped; DIRECTION is read-only zero
      wr(1'b0, 2'd2, 32'hFFFF_FFFF);
      rd(2'd2);
      check("mask_width_trunc", rd_a, 32'h3);
      wr(1'b0, 2'd1, 32'hFFFF_FFFF);
      rd(2'd1);
      check("direction_zero", rd_a, 32'h0);
      wr(1'b0, 2'd2, 32'h1);

      // Falling edge latency: ecap/irq at SYNC_STAGES+1, readdata one later
      address  = 2'd3;
      in_a[0]  = 1'b0;
      cyc(2);
      check("edge_not_yet", 32'(irq_a), 32'h0);
      cyc(1);
      check("edge_irq_at_3", 32'(irq_a), 32'h1);
      check("edge_rd_lags", rd_a, 32'h0);
      cyc(1);
      check("edge_rd_ecap", rd_a, 32'h1);
      rd(2'd0);
      check("edge_data", rd_a, 32'h2);
      wr(1'b0, 2'd3, 32'h1);
      check("clr_irq_low", 32'(irq_a), 32'h0);
      rd(2'd3);
      check("clr_ecap_zero", rd_a, 32'h0);

      // Clear and a new falling edge in the same cycle: set wins
      in_a[0] = 1'b1;
      cyc(4);
      check("rise_ignored", 32'(irq_a), 32'h0);
      in_a[0] = 1'b0;
      cyc(3);
      check("fall1_irq", 32'(irq_a), 32'h1);
      in_a[0] = 1'b1;
      cyc(4);
      in_a[0] = 1'b0;
      cyc(2);
      wr(1'b0, 2'd3, 32'h1);
      check("set_wins_irq", 32'(irq_a), 32'h1);
      rd(2'd3);
      check("set_wins_ecap", rd_a, 32'h1);
      wr(1'b0, 2'd3, 32'h1);
      check("clr2_irq_low", 32'(irq_a), 32'h0);

      // Masking and unmasking with bit 1 captured
      wr(1'b0, 2'd2, 32'h0);
      in_a[1] = 1'b0;
      cyc(4);
      check("masked_irq", 32'(irq_a), 32'h0);
      rd(2'd3);
      check("masked_ecap", rd_a, 32'h2);
      wr(1'b0, 2'd2, 32'h2);
      check("unmask_irq", 32'(irq_a), 32'h1);
      wr(1'b0, 2'd3, 32'h1);
      check("wrong_bit_clr_irq", 32'(irq_a), 32'h1);
      rd(2'd3);
      check("wrong_bit_clr_ecap", rd_a, 32'h2);
      wr(1'b0, 2'd2, 32'h0);
      check("remask_irq", 32'(irq_a), 32'h0);
      rd(2'd3);
      check("remask_keeps_ecap", rd_a, 32'h2);

      // Reset mid-operation, release with idle inputs
      reset_n = 1'b0;
      #1;
      check("midrst_readdata", rd_a, 32'h0);
      in_a = 2'b11;
      cyc(2);
      reset_n = 1'b1;
      wr(1'b0, 2'd2, 32'h3);
      cyc(4);
      check("rel_irq", 32'(irq_a), 32'h0);
      rd(2'd3);
      check("rel_ecap", rd_a, 32'h0);
      rd(2'd0);
      check("rel_data", rd_a, 32'h3);

      // Any-edge capture on the 8-bit instance
      in_b = 8'h0F;
      cyc(4);
      rd(2'd3);
      check("b_ecap_first", rd_b, 32'hF0);
      check("b_irq_masked", 32'(irq_b), 32'h0);
      rd(2'd0);
      check("b_data_low", rd_b, 32'h0F);
      wr(1'b1, 2'd3, 32'hF0);
      rd(2'd3);
      check("b_ecap_cleared", rd_b, 32'h00);
      in_b = 8'hFF;
      cyc(4);
      rd(2'd3);
      check("b_ecap_second", rd_b, 32'hF0);
      rd(2'd1);
      check("b_direction", rd_b, 32'h0);
`else
      // Bouncing input: filtered value moves only after 4 stable synchronised cycles
      wr(1'b0, 2'd2, 32'h1);
      address = 2'd3;
      in_a[0] = 1'b0;
      cyc(2);
      in_a[0] = 1'b1;
      cyc(2);
      in_a[0] = 1'b0;
      cyc(5);
      check("db_irq_not_yet", 32'(irq_a), 32'h0);
      check("db_ecap_not_yet", rd_a, 32'h0);
      cyc(1);
      check("db_irq_set", 32'(irq_a), 32'h1);
      rd(2'd0);
      check("db_data", rd_a, 32'h2);
      rd(2'd3);
      check("db_one_capture", rd_a, 32'h1);

      // 3-clock glitch is filtered out
      in_a[0] = 1'b1;
      cyc(3);
      in_a[0] = 1'b0;
      cyc(8);
      rd(2'd0);
      check("db_glitch_data", rd_a, 32'h2);
      rd(2'd3);
      check("db_glitch_ecap", rd_a, 32'h1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
